// File: rtl/quadc_pkg.sv
// Shared types and constants for the quad-ADC snapshot capture stage.
// The lane-to-word packing lives here so every user agrees on the bit order.
package quadc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } snap_state_t;

  localparam int SAMPLE_W  = 8;
  localparam int NUM_LANES = 4;
  localparam int WORD_W    = 32;

  // adc0 occupies the least significant byte.
  function automatic logic [WORD_W-1:0] pack_lanes(
    input logic [SAMPLE_W-1:0] lane0,
    input logic [SAMPLE_W-1:0] lane1,
    input logic [SAMPLE_W-1:0] lane2,
    input logic [SAMPLE_W-1:0] lane3
  );
    return {lane3, lane2, lane1, lane0};
  endfunction

endpackage

// File: rtl/quadc_snap_ram.sv
// Simple dual-port capture RAM: one write port, one registered read port.
// Array contents are never reset so the tools can map it onto block RAM.
module quadc_snap_ram
  import quadc_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WORD_W-1:0] rd_data
);

  logic [WORD_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Only the output register is cleared; stored samples survive reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/quadc_snap_capture.sv
// Snapshot capture: arm, wait for an immediate or sync-edge trigger, then
// store exactly 2^ADDR_W consecutive valid packed samples into RAM.
module quadc_snap_capture
  import quadc_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic                adc0_clk,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] adc0_data,
  input  logic [SAMPLE_W-1:0] adc1_data,
  input  logic [SAMPLE_W-1:0] adc2_data,
  input  logic [SAMPLE_W-1:0] adc3_data,
  input  logic                valid,
  input  logic                sync,
  input  logic                arm,
  input  logic                trig_src,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [WORD_W-1:0]   rd_data,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W:0]     wr_count
);

  snap_state_t state;
  snap_state_t next_state;
  logic        sync_d;
  logic        sync_rise;
  logic        trig;
  logic        wr_en;
  logic        clear_count;
  logic        last_addr;

  assign sync_rise = sync & ~sync_d;
  assign trig      = valid & (~trig_src | sync_rise);
  assign last_addr = (wr_count[ADDR_W-1:0] == {ADDR_W{1'b1}});

  always_ff @(posedge adc0_clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // A trigger coinciding with arm in IDLE/DONE is not taken: arming wins.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (arm) next_state = ARMED;
      ARMED:   if (trig) next_state = CAPTURE;
      CAPTURE: if (valid && last_addr) next_state = DONE;
      DONE:    if (arm) next_state = ARMED;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    wr_en       = 1'b0;
    clear_count = 1'b0;
    unique case (state)
      IDLE: begin
        clear_count = arm;
      end
      ARMED: begin
        busy  = 1'b1;
        wr_en = trig;
      end
      CAPTURE: begin
        busy  = 1'b1;
        wr_en = valid;
      end
      DONE: begin
        done        = 1'b1;
        clear_count = arm;
      end
      default: ;
    endcase
  end

  // wr_count is 0 whenever ARMED, so it doubles as the write address.
  always_ff @(posedge adc0_clk or posedge reset) begin
    if (reset) begin
      sync_d   <= 1'b0;
      wr_count <= '0;
    end else begin
      sync_d <= sync;
      if (clear_count) begin
        wr_count <= '0;
      end else if (wr_en) begin
        wr_count <= wr_count + {{ADDR_W{1'b0}}, 1'b1};
      end
    end
  end

  quadc_snap_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (adc0_clk),
    .rst     (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_count[ADDR_W-1:0]),
    .wr_data (pack_lanes(adc0_data, adc1_data, adc2_data, adc3_data)),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_quadc_snap_capture.sv
// Bench for quadc_snap_capture: whole stimulus runs are generated up front and
// the expected capture is derived by scanning them; readback goes via a scoreboard.
module tb_quadc_snap_capture;

  localparam int ADDR_W = 4;
  localparam int DEPTH  = 2**ADDR_W;
  localparam int N      = 100;

  logic              adc0_clk = 1'b0;
  logic              reset;
  logic [7:0]        adc0_data, adc1_data, adc2_data, adc3_data;
  logic              valid, sync, arm, trig_src;
  logic [ADDR_W-1:0] rd_addr;
  logic [31:0]       rd_data;
  logic              busy, done;
  logic [ADDR_W:0]   wr_count;

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [31:0] exp_q[$];
  int          addr_q[$];
  event        rd_sample;

  bit          stim_a[N];
  bit          stim_v[N];
  bit          stim_s[N];
  logic [31:0] stim_w[N];
  logic [31:0] ref_mem[DEPTH];
  bit          prev_sync;

  quadc_snap_capture #(.ADDR_W(ADDR_W)) dut (
    .adc0_clk  (adc0_clk),
    .reset     (reset),
    .adc0_data (adc0_data),
    .adc1_data (adc1_data),
    .adc2_data (adc2_data),
    .adc3_data (adc3_data),
    .valid     (valid),
    .sync      (sync),
    .arm       (arm),
    .trig_src  (trig_src),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .busy      (busy),
    .done      (done),
    .wr_count  (wr_count)
  );

  always #5 adc0_clk = ~adc0_clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running, required to finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Scoreboard monitor: every read strobe pops one expectation.
  initial begin
    forever begin
      @(rd_sample);
      if (exp_q.size() == 0) begin
        checkOutput("sb_underflow", 32'd1, 32'd0);
      end else begin
        checkOutput($sformatf("rd[%0d]", addr_q.pop_front()), rd_data, exp_q.pop_front());
      end
    end
  end

  task automatic applyStimulus(input bit a, input bit v, input bit s, input logic [31:0] w);
    arm   = a;
    valid = v;
    sync  = s;
    {adc3_data, adc2_data, adc1_data, adc0_data} = w;
    @(posedge adc0_clk);
    #1;
    prev_sync = s;
  endtask

  task automatic idleInputs();
    arm = 1'b0; valid = 1'b0; sync = 1'b0;
    {adc3_data, adc2_data, adc1_data, adc0_data} = 32'h0;
  endtask

  task automatic doReset();
    idleInputs();
    #1 reset = 1'b1;
    #1;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_wr_count", 32'(wr_count), 32'd0);
    checkOutput("rst_rd_data", rd_data, 32'd0);
    @(negedge adc0_clk);
    reset = 1'b0;
    prev_sync = 1'b0;
    @(posedge adc0_clk);
    #1;
  endtask

  task automatic readWord(input int a, input logic [31:0] expected);
    rd_addr = ADDR_W'(a);
    exp_q.push_back(expected);
    addr_q.push_back(a);
    @(posedge adc0_clk);
    #1;
    @(posedge adc0_clk);
    #1;
    -> rd_sample;
  endtask

  task automatic readAll();
    for (int a = 0; a < DEPTH; a++) readWord(a, ref_mem[a]);
  endtask

  function automatic logic [31:0] rampWord(input int i, input logic [7:0] xr);
    return {8'(4*i+3) ^ xr, 8'(4*i+2) ^ xr, 8'(4*i+1) ^ xr, 8'(4*i) ^ xr};
  endfunction

  task automatic newStim(input bit ramp, input logic [7:0] xr);
    for (int k = 0; k < N; k++) begin
      stim_a[k] = (k == 0);
      stim_v[k] = 1'b1;
      stim_s[k] = 1'b0;
      stim_w[k] = ramp ? rampWord(k - 1, xr) : $urandom;
    end
  endtask

  // Expected capture: after the arm cycle, the first trigger-qualified valid
  // sample plus the following valid samples, 16 words in total.
  task automatic runCapture(input bit src, input int reset_at, input string tag);
    int  cnt_after[N];
    int  trig_idx = -1;
    int  widx = 0;
    int  last = -1;
    bit  p = prev_sync;
    bit  rise;
    for (int k = 0; k < N; k++) begin
      rise = stim_s[k] && !p;
      p = stim_s[k];
      if (k > 0 && widx < DEPTH) begin
        if (trig_idx < 0) begin
          if (stim_v[k] && (!src || rise)) begin
            trig_idx = k;
            ref_mem[0] = stim_w[k];
            widx = 1;
          end
        end else if (stim_v[k]) begin
          ref_mem[widx] = stim_w[k];
          widx++;
        end
        if (widx == DEPTH && last < 0) last = k;
      end
      cnt_after[k] = widx;
    end
    if (last < 0 && reset_at < 0) begin
      checkOutput({tag, "_stim_too_short"}, 32'd1, 32'd0);
    end
    trig_src = src;
    for (int k = 0; k < N; k++) begin
      applyStimulus(stim_a[k], stim_v[k], stim_s[k], stim_w[k]);
      checkOutput($sformatf("%s_busy@%0d", tag, k), 32'(busy),
                  32'(last < 0 || k < last));
      checkOutput($sformatf("%s_done@%0d", tag, k), 32'(done),
                  32'(last >= 0 && k >= last));
      checkOutput($sformatf("%s_wr_count@%0d", tag, k), 32'(wr_count), 32'(cnt_after[k]));
      if (k == reset_at) begin
        doReset();
        return;
      end
    end
    idleInputs();
  endtask

  initial begin
    reset = 1'b0;
    rd_addr = '0;
    trig_src = 1'b0;
    prev_sync = 1'b0;
    idleInputs();
    repeat (2) @(posedge adc0_clk);
    doReset();

    $display("[TB] immediate trigger, ramp");
    newStim(1'b1, 8'h00);
    runCapture(1'b0, -1, "imm");
    readAll();
    readWord(5, 32'h17161514);

    $display("[TB] sync trigger with lost edge");
    newStim(1'b0, 8'h00);
    stim_v[10] = 1'b0;
    stim_s[10] = 1'b1;
    for (int k = 37; k < N; k++) stim_s[k] = 1'b1;
    runCapture(1'b1, -1, "sync");
    readAll();
    readWord(0, stim_w[37]);

    $display("[TB] gapped valid");
    newStim(1'b0, 8'h00);
    for (int k = 0; k < N; k++) stim_v[k] = (k % 2 == 1);
    runCapture(1'b0, -1, "gap");
    readAll();

    $display("[TB] arm while capturing");
    newStim(1'b1, 8'h00);
    stim_a[8] = 1'b1;
    runCapture(1'b0, -1, "armmid");
    readAll();

    $display("[TB] reset mid-capture then clean capture");
    newStim(1'b0, 8'h00);
    runCapture(1'b0, 7, "rstmid");
    newStim(1'b0, 8'h00);
    runCapture(1'b0, -1, "postrst");
    readAll();

    $display("[TB] re-arm from done with new pattern");
    newStim(1'b1, 8'hA5);
    runCapture(1'b0, -1, "rearm");
    readAll();

    for (int r = 0; r < 3; r++) begin
      $display("[TB] random run %0d", r);
      newStim(1'b0, 8'h00);
      for (int k = 1; k < N; k++) begin
        stim_v[k] = (k >= 60) || ($urandom_range(9, 0) < 7);
        stim_s[k] = (k >= 60) ? (k % 2 == 1) : 1'($urandom_range(1, 0));
      end
      runCapture(1'($urandom_range(1, 0)), -1, $sformatf("rand%0d", r));
      readAll();
    end

    @(posedge adc0_clk);
    #1;
    checkOutput("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
